// File: rtl/ysyx_24080006_region_guard.sv
// rtl/ysyx_24080006_region_guard.sv - registered LSU-to-bus region/permission checker with injected latency
// Lowest-index region wins on overlap; illegal accesses are answered locally with resp_err.
module ysyx_24080006_region_guard #(
  parameter int NREGION = 8,
  parameter int AW      = 32,
  parameter int LATW    = 4,
  parameter int CNTW    = 16,
  parameter logic [NREGION*AW-1:0] REGION_BASE = {
    32'ha000_0000, 32'h3000_0000, 32'h0f00_0000, 32'h2100_0000,
    32'h1001_1000, 32'h1000_2000, 32'h1000_0000, 32'h0200_0000},
  parameter logic [NREGION*AW-1:0] REGION_LIMIT = {
    32'ha3ff_ffff, 32'h30ff_ffff, 32'h0f00_1fff, 32'h211f_ffff,
    32'h1001_1007, 32'h1000_200f, 32'h1000_0fff, 32'h0200_ffff},
  parameter logic [NREGION*3-1:0] REGION_ATTR = {
    3'b011, 3'b001, 3'b011, 3'b111, 3'b101, 3'b111, 3'b111, 3'b101},
  parameter logic [NREGION*LATW-1:0] REGION_LAT = {
    4'd6, 4'd6, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0},
  localparam int RW = (NREGION > 1) ? $clog2(NREGION) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_addr,
  input  logic            req_we,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AW-1:0]   out_addr,
  output logic            out_we,
  output logic [RW-1:0]   out_region,
  output logic            out_perip,
  output logic            resp_valid,
  output logic            resp_err,
  input  logic            err_clr,
  output logic            err_flag,
  output logic [AW-1:0]   err_addr,
  output logic [CNTW-1:0] err_cnt,
  output logic [CNTW-1:0] perip_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_WAIT, S_FWD, S_RESP} state_t;

  state_t          r_state;
  logic            r_req_ready;
  logic            r_out_valid;
  logic [AW-1:0]   r_addr;
  logic            r_we;
  logic [RW-1:0]   r_region;
  logic            r_perip;
  logic [LATW-1:0] r_cnt;
  logic            r_resp_valid;
  logic            r_resp_err;
  logic            r_err_flag;
  logic [AW-1:0]   r_err_addr;
  logic [CNTW-1:0] r_err_cnt;
  logic [CNTW-1:0] r_perip_cnt;

  logic            w_hit;
  logic [RW-1:0]   w_idx;
  logic [2:0]      w_attr;
  logic [LATW-1:0] w_lat;
  logic            w_fault;

  // Scan from the top index down so the lowest matching index is the last assignment.
  always_comb begin
    w_hit  = 1'b0;
    w_idx  = '0;
    w_attr = '0;
    w_lat  = '0;
    for (int i = NREGION - 1; i >= 0; i--) begin
      if (r_addr >= REGION_BASE[i*AW +: AW] && r_addr <= REGION_LIMIT[i*AW +: AW]) begin
        w_hit  = 1'b1;
        w_idx  = RW'(i);
        w_attr = REGION_ATTR[i*3 +: 3];
        w_lat  = REGION_LAT[i*LATW +: LATW];
      end
    end
  end

  assign w_fault = !w_hit || (r_we && !w_attr[1]) || (!r_we && !w_attr[0]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_out_valid  <= 1'b0;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_region     <= '0;
      r_perip      <= 1'b0;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_err_flag   <= 1'b0;
      r_err_addr   <= '0;
      r_err_cnt    <= '0;
      r_perip_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr      <= req_addr;
            r_we        <= req_we;
            r_req_ready <= 1'b0;
            r_state     <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_fault) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_region <= w_idx;
            r_perip  <= w_attr[2];
            r_cnt    <= w_lat;
            if (w_lat != '0) begin
              r_state <= S_WAIT;
            end else begin
              r_out_valid <= 1'b1;
              r_state     <= S_FWD;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == LATW'(1)) begin
            r_out_valid <= 1'b1;
            r_state     <= S_FWD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_FWD: begin
          if (out_ready) begin
            r_out_valid  <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_state      <= S_RESP;
            if (r_perip && r_perip_cnt != '1) r_perip_cnt <= r_perip_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= S_IDLE;
          if (r_resp_err) begin
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
            if (!r_err_flag) r_err_addr <= r_addr;
            r_err_flag <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
      // Placed last so a clear overrides an error being logged in the same cycle.
      if (err_clr) begin
        r_err_flag <= 1'b0;
        r_err_addr <= '0;
        r_err_cnt  <= '0;
      end
    end
  end

  assign req_ready  = r_req_ready;
  assign out_valid  = r_out_valid;
  assign out_addr   = r_addr;
  assign out_we     = r_we;
  assign out_region = r_region;
  assign out_perip  = r_perip;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign err_flag   = r_err_flag;
  assign err_addr   = r_err_addr;
  assign err_cnt    = r_err_cnt;
  assign perip_cnt  = r_perip_cnt;

endmodule

// File: doc/ysyx_24080006_region_guard.md
Name: ysyx_24080006_region_guard

Overview:
- Parametrised, registered access checker between the LSU and the bus.
- Decodes each request against a table of NREGION address regions, each with read/write permission, a peripheral flag and an injected latency.
- Forwards legal accesses downstream after the region's delay.
- Answers illegal accesses locally with an error response, and keeps sticky error and peripheral-access statistics for difftest skip and debug.

Parameters:
- NREGION, 8: number of regions; must be ≥1.
- AW, 32: address width.
- LATW, 4: latency field width.
- CNTW, 16: statistics counter width.
- REGION_BASE, {a000_0000,3000_0000,0f00_0000,2100_0000,1001_1000,1000_2000,1000_0000,0200_0000}: packed NREGION×AW base addresses; index 0 is in the LSBs.
- REGION_LIMIT, {a3ff_ffff,30ff_ffff,0f00_1fff,211f_ffff,1001_1007,1000_200f,1000_0fff,0200_ffff}: packed inclusive limits.
- REGION_ATTR, {3'b011,3'b001,3'b011,3'b111,3'b101,3'b111,3'b111,3'b101}: packed {perip,W,R} per region.
- REGION_LAT, {6,6,6,0,0,0,0,0}: packed LATW-bit injected wait cycles per region.

Ports:
- clock, in, 1: clock.
- reset, in, 1: asynchronous active-high reset.
- req_valid, in, 1: request valid.
- req_ready, out, 1: guard can accept a request.
- req_addr, in, AW: request address.
- req_we, in, 1: 1 = store, 0 = load.
- out_valid, out, 1: forwarded request valid.
- out_ready, in, 1: downstream accepts the forwarded request.
- out_addr, out, AW: forwarded address.
- out_we, out, 1: forwarded write flag.
- out_region, out, $clog2(NREGION) (min 1): index of the matched region.
- out_perip, out, 1: matched region is a peripheral (difftest skip).
- resp_valid, out, 1: one-cycle completion pulse.
- resp_err, out, 1: completion is an error; qualified by resp_valid.
- err_clr, in, 1: clears the sticky error state.
- err_flag, out, 1: sticky "an error has occurred".
- err_addr, out, AW: address of the first error since the last clear.
- err_cnt, out, CNTW: saturating count of errors.
- perip_cnt, out, CNTW: saturating count of forwarded peripheral accesses.

Behaviour:
Reset values:
- Async reset forces state IDLE.
- req_ready=1; out_valid=0; resp_valid=0; resp_err=0; err_flag=0.
- err_addr, err_cnt, perip_cnt, out_addr, out_we, out_region, out_perip all 0.
- Reset asserted mid-operation abandons the transaction: no response, out_valid drops immediately.

States: IDLE, CHECK, WAIT, FWD, RESP.
- IDLE: req_ready=1. On req_valid, capture addr/we and go to CHECK. req_ready=0 in every other state; there is no back-to-back acceptance.
- CHECK (exactly one cycle):
  - Hit = base ≤ addr ≤ limit, unsigned, limit inclusive.
  - On multiple hits, the lowest index wins.
  - Permission fault = no hit, or (we & !W), or (!we & !R).
  - Fault: set resp_err, go to RESP.
  - Otherwise load the latency counter with REGION_LAT[idx], latch out_region/out_perip, and go to WAIT if lat>0, else FWD.
- WAIT: decrement the counter each cycle; when it reaches 1, go to FWD. Gives exactly lat cycles in WAIT.
- FWD: out_valid=1; out_addr/out_we/out_region/out_perip held stable until out_ready. On the out_valid&out_ready cycle: perip_cnt += out_perip (saturating at all-ones), go to RESP with resp_err=0.
- RESP: resp_valid=1 for one cycle, then IDLE.

Latency:
- Legal access: request accept to out_valid = 2+lat cycles.
- Error access: accept to resp_valid = 2 cycles.

Error bookkeeping, updated on the RESP cycle when resp_err=1:
- err_cnt += 1, saturating.
- err_addr is written only if err_flag was 0.
- err_flag set.

err_clr:
- Clears err_flag, err_addr and err_cnt.
- If it coincides with an error RESP, the clear wins and this error is dropped.

Test Plan:
- Load 0x0f00_0010: out_valid exactly 8 cycles after accept; out_region=5, out_perip=0; out_ready=1 → resp_valid next cycle, resp_err=0.
- Store 0x1000_0000: out_valid 2 cycles after accept; out_perip=1, out_region=1; hold out_ready=0 for 5 cycles → outputs stable; after handshake perip_cnt=1.
- Store 0x3000_0000 (FLASH, read-only) → no out_valid; resp_valid with resp_err=1 2 cycles after accept; err_flag=1, err_addr=0x3000_0000, err_cnt=1.
- Load 0x0000_0000 then load 0x5000_0000 (both unmapped) → err_cnt=2, err_addr stays 0x0000_0000; pulse err_clr → err_flag=0, err_cnt=0, err_addr=0.
- Boundary: load 0x1001_1007 → forwarded (region 3); load 0x1001_1008 → error. Load 0xa3ff_ffff → forwarded with lat 6.
- Assert reset during WAIT of an SDRAM load → out_valid=0 and req_ready=1 immediately; no resp_valid ever issued for it; the next request is served normally.
